// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared types for the fifo-draining UART transmitter.
//  state_t : frame sequencer states IDLE/START/DATA/STOP
//  Line levels for idle/stop and start bits.
package uart_tx_fifo_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: 8N1-style UART transmitter reading straight from a
// byte fifo. One read strobe per byte, back-to-back frames while data remains.
// Ports:
//  i_clk              system clock
//  i_reset            synchronous active-high reset
//  i_data_available   fifo has a readable head byte
//  i_read_data        fifo head byte (combinational from the fifo)
//  o_read_strobe      one-cycle pop pulse (registered)
//  o_tx               serial line, idle/stop = 1, start = 0
//  o_busy             high from frame load to end of last stop bit
//  o_frame_done       pulse in the last clock of the last stop bit
module uart_tx_fifo_drain #(
  parameter int DIVISOR   = 16,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_data_available,
  input  logic [DATA_BITS-1:0] i_read_data,
  output logic                 o_read_strobe,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_frame_done
);
  import uart_tx_fifo_drain_pkg::*;

  localparam int TW = $clog2(DIVISOR);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TMAX      = TW'(DIVISOR - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  state_t               r_state, w_state_nxt;
  logic [TW-1:0]        r_timer, w_timer_nxt;
  logic [DATA_BITS-1:0] r_sr,    w_sr_nxt;
  logic [BW-1:0]        r_bitcnt, w_bitcnt_nxt;
  logic                 r_tx, w_tx_nxt;
  logic                 r_rs, w_rs_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_fd, w_fd_nxt;
  logic                 w_tick, w_load, w_last_stop;
  logic [DATA_BITS-1:0] w_sr_shift;

  assign w_tick      = (r_timer == '0);
  assign w_last_stop = (r_bitcnt == LAST_STOP);
  assign w_sr_shift  = {1'b0, r_sr[DATA_BITS-1:1]};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_timer  <= '0;
      r_sr     <= '0;
      r_bitcnt <= '0;
      r_tx     <= LINE_IDLE;
      r_rs     <= 1'b0;
      r_busy   <= 1'b0;
      r_fd     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_sr     <= w_sr_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_tx     <= w_tx_nxt;
      r_rs     <= w_rs_nxt;
      r_busy   <= w_busy_nxt;
      r_fd     <= w_fd_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_sr_nxt     = r_sr;
    w_bitcnt_nxt = r_bitcnt;
    w_tx_nxt     = r_tx;
    w_rs_nxt     = 1'b0;
    w_busy_nxt   = r_busy;
    w_fd_nxt     = 1'b0;
    w_load       = 1'b0;

    // Bit timer runs only inside a frame and restarts on every bit.
    if (r_state != ST_IDLE)
      w_timer_nxt = w_tick ? TMAX : r_timer - TW'(1);

    case (r_state)
      ST_IDLE: begin
        w_tx_nxt   = LINE_IDLE;
        w_busy_nxt = 1'b0;
        w_load     = i_data_available;
      end
      ST_START: begin
        if (w_tick) begin
          w_state_nxt  = ST_DATA;
          w_tx_nxt     = r_sr[0];
          w_sr_nxt     = w_sr_shift;
          w_bitcnt_nxt = '0;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_bitcnt == LAST_DATA) begin
            w_state_nxt  = ST_STOP;
            w_tx_nxt     = LINE_IDLE;
            w_bitcnt_nxt = '0;
          end else begin
            w_tx_nxt     = r_sr[0];
            w_sr_nxt     = w_sr_shift;
            w_bitcnt_nxt = r_bitcnt + BW'(1);
          end
        end
      end
      ST_STOP: begin
        // Registered pulse: set one clock early so it lands on the final clock.
        if (w_last_stop && r_timer == TW'(1))
          w_fd_nxt = 1'b1;
        if (w_tick) begin
          if (!w_last_stop) begin
            w_bitcnt_nxt = r_bitcnt + BW'(1);
          end else if (i_data_available) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_timer_nxt = '0;
            w_busy_nxt  = 1'b0;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Common load path from IDLE or the final stop clock (zero-gap frames).
    if (w_load) begin
      w_state_nxt  = ST_START;
      w_timer_nxt  = TMAX;
      w_sr_nxt     = i_read_data;
      w_bitcnt_nxt = '0;
      w_tx_nxt     = LINE_START;
      w_rs_nxt     = 1'b1;
      w_busy_nxt   = 1'b1;
    end
  end

  assign o_tx          = r_tx;
  assign o_read_strobe = r_rs;
  assign o_busy        = r_busy;
  assign o_frame_done  = r_fd;

endmodule
